conv_window_generator: RTL and testbench

Streaming sliding-window generator at the front of the convolutional layer. It accepts a raster-order pixel stream of one image, buffers K-1 previous rows, and emits every valid K×K window as one packed word of K*K elements. That word is the `input_data` vector consumed by the layer's inner product units. Stride is 1 with no padding, so each frame yields (IMG_WIDTH-K+1)×(IMG_HEIGHT-K+1) windows.

---
 rtl/conv_window_generator.sv | 160 ++++++++++++++++
 tb/tb_conv_window_generator.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_generator.sv
// conv_window_generator
// Streaming K x K sliding-window generator (stride 1, no padding) for the
// front of the convolutional layer. Pixels arrive in raster order; K-1 line
// buffers keep the previous rows so that every valid window is emitted as a
// single packed word.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_data    : pixel, raster order
//   in_valid   : pixel present
//   in_ready   : pixel accepted when in_valid && in_ready
//   out_data   : packed window, element r*K+c at [D_WIDTH*(i+1)-1 : D_WIDTH*i]
//   out_valid  : window present
//   out_ready  : window consumed when out_valid && out_ready
//   out_last   : final window of the frame (qualified by out_valid)
module conv_window_generator #(
  parameter int K          = 3,
  parameter int D_WIDTH    = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [D_WIDTH-1:0]     in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [D_WIDTH*K*K-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  localparam int CW    = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int OUT_W = D_WIDTH * K * K;

  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic [D_WIDTH-1:0] win_q [0:K-1][0:K-1];
  logic [D_WIDTH-1:0] win_d [0:K-1][0:K-1];
  logic [D_WIDTH-1:0] col_new [0:K-1];
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;

  logic accept;
  logic pos_ok;
  logic produce;
  logic frame_end;

  // A held window blocks the input so it cannot be overwritten.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign frame_end = (row_q == RW'(IMG_HEIGHT - 1)) && (col_q == CW'(IMG_WIDTH - 1));
  assign produce   = accept && pos_ok;

  // Only positions with a full K x K neighbourhood inside the current frame
  // emit; this also keeps stale rows from a previous frame out of the output.
  if (K == 1) begin : g_pos_k1
    assign pos_ok = 1'b1;
  end else begin : g_pos_kn
    assign pos_ok = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
  end

  // New right-hand window column: buffered rows oldest first, then the
  // incoming pixel at the bottom.
  assign col_new[K-1] = in_data;

  if (K > 1) begin : g_lb
    // Buffer 0 holds the oldest row. Contents are never reset: stale data is
    // masked by the position gate above.
    logic [D_WIDTH-1:0] lb_q [0:K-2][0:IMG_WIDTH-1];

    always_ff @(posedge clk) begin
      if (accept) begin
        for (int j = 0; j < K - 2; j++) begin
          lb_q[j][col_q] <= lb_q[j+1][col_q];
        end
        lb_q[K-2][col_q] <= in_data;
      end
    end

    for (genvar j = 0; j < K - 1; j++) begin : g_tap
      assign col_new[j] = lb_q[j][col_q];
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_HEIGHT - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][K-1] = col_new[r];
      end
    end
  end

  // The updated window is packed straight into the output register so it is
  // visible the cycle after the completing pixel is accepted.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (produce) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          out_data_d[D_WIDTH*(r*K+c) +: D_WIDTH] = win_d[r][c];
        end
      end
      out_valid_d = 1'b1;
      out_last_d  = frame_end;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      win_q       <= win_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_window_generator.sv
// Bench for conv_window_generator: a K=3, 4x4 instance driven through directed
// and randomized streams against an image-array reference model, plus a K=1,
// 2x2 instance for the degenerate pass-through case.
module tb_conv_window_generator;

  localparam int K  = 3;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int OW = DW * K * K;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  logic [DW-1:0] c1_in_data;
  logic          c1_in_valid;
  logic          c1_in_ready;
  logic [DW-1:0] c1_out_data;
  logic          c1_out_valid;
  logic          c1_out_ready;
  logic          c1_out_last;

  conv_window_generator #(.K(K), .D_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  conv_window_generator #(.K(1), .D_WIDTH(DW), .IMG_WIDTH(2), .IMG_HEIGHT(2)) dut_k1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (c1_in_data),
    .in_valid  (c1_in_valid),
    .in_ready  (c1_in_ready),
    .out_data  (c1_out_data),
    .out_valid (c1_out_valid),
    .out_ready (c1_out_ready),
    .out_last  (c1_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: the current frame as a plain image array; a window is the
  // K x K block whose bottom-right corner is the pixel just accepted.
  typedef struct {
    logic [OW-1:0] d;
    logic          l;
  } win_t;

  logic [DW-1:0] img [0:H-1][0:W-1];
  int            mrow, mcol;
  win_t          exp_q[$];
  logic [OW-1:0] got_d[$];
  logic          got_l[$];
  logic          held_vld;
  logic [OW-1:0] held_data;
  logic          held_last;
  logic          acc;

  task automatic model_reset();
    mrow     = 0;
    mcol     = 0;
    held_vld = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [DW-1:0] d);
    win_t w;
    w.d = '0;
    w.l = 1'b0;
    img[mrow][mcol] = d;
    if (mrow >= K - 1 && mcol >= K - 1) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          w.d[(r*K+c)*DW +: DW] = img[mrow-K+1+r][mcol-K+1+c];
      w.l = (mrow == H - 1) && (mcol == W - 1);
      exp_q.push_back(w);
    end
    if (mcol == W - 1) begin
      mcol = 0;
      mrow = (mrow == H - 1) ? 0 : mrow + 1;
    end else begin
      mcol++;
    end
  endtask

  // One clock cycle: drive on the falling edge, sample 1 ns later.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy);
    win_t w;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    check("in_ready", OW'(in_ready), OW'(!out_valid || ordy));
    check("out_valid", OW'(out_valid), OW'(exp_q.size() != 0));
    if (held_vld && out_valid) begin
      check("hold_data", out_data, held_data);
      check("hold_last", OW'(out_last), OW'(held_last));
    end
    if (out_valid && ordy) begin
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("win_data", out_data, w.d);
        check("win_last", OW'(out_last), OW'(w.l));
      end
      got_d.push_back(out_data);
      got_l.push_back(out_last);
      held_vld = 1'b0;
    end else if (out_valid) begin
      held_vld  = 1'b1;
      held_data = out_data;
      held_last = out_last;
    end else begin
      held_vld = 1'b0;
    end
    acc = iv && in_ready;
    if (acc) model_accept(d);
  endtask

  task automatic send_frame(input int base, input int n, input int vpct, input int rpct, input bit rnd);
    int            i;
    int            budget;
    logic [DW-1:0] px;
    logic          iv;
    logic          rd;
    i      = 0;
    budget = 0;
    px     = rnd ? DW'($urandom) : DW'(base);
    while (i < n && budget < 2000) begin
      iv = ($urandom_range(99, 0) < vpct);
      rd = ($urandom_range(99, 0) < rpct);
      step(iv, iv ? px : DW'(0), rd);
      if (acc) begin
        i++;
        px = rnd ? DW'($urandom) : DW'(base + i);
      end
      budget++;
    end
    if (i < n) check("send_timeout", OW'(i), OW'(n));
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      step(1'b0, '0, 1'b1);
      budget++;
    end
    check("drain_empty", OW'(exp_q.size()), OW'(0));
    step(1'b0, '0, 1'b1);
  endtask

  function automatic logic [OW-1:0] win4(input int s);
    logic [OW-1:0] v;
    v = '0;
    for (int i = 0; i < K * K; i++)
      v[i*DW +: DW] = DW'(s + (i / K) * W + (i % K));
    return v;
  endfunction

  task automatic compare_basic(input int base);
    int starts [4];
    starts = '{0, 1, 4, 5};
    check("n_windows", OW'(got_d.size()), OW'(4));
    if (got_d.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("basic_win", got_d[i], win4(base + starts[i]));
        check("basic_last", OW'(got_l[i]), OW'(i == 3));
      end
    end
  endtask

  task automatic clear_log();
    got_d.delete();
    got_l.delete();
  endtask

  initial begin
    int k1v [4];
    int nlast;
    k1v = '{9, 8, 7, 6};

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b1;
    c1_in_valid  = 1'b0;
    c1_in_data   = '0;
    c1_out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", OW'(out_valid), OW'(0));
    check("rst_out_last", OW'(out_last), OW'(0));
    check("rst_out_data", out_data, OW'(0));
    check("rst_in_ready", OW'(in_ready), OW'(1));
    rst_n = 1'b1;

    // Degenerate K=1: registered pass-through.
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      c1_in_valid = (i < 4);
      c1_in_data  = (i < 4) ? DW'(k1v[i]) : DW'(0);
      #1;
      check("k1_in_ready", OW'(c1_in_ready), OW'(1));
      if (i == 0) begin
        check("k1_idle", OW'(c1_out_valid), OW'(0));
      end else begin
        check("k1_valid", OW'(c1_out_valid), OW'(1));
        check("k1_data", OW'(c1_out_data), OW'(k1v[i-1]));
        check("k1_last", OW'(c1_out_last), OW'(i == 4));
      end
    end
    @(negedge clk);
    #1;
    check("k1_done", OW'(c1_out_valid), OW'(0));

    // Basic 4x4 frame.
    clear_log();
    send_frame(0, 16, 100, 100, 1'b0);
    drain();
    compare_basic(0);

    // Backpressure after the first window.
    clear_log();
    for (int p = 0; p <= 10; p++) step(1'b1, DW'(p), 1'b1);
    for (int n = 0; n < 5; n++) begin
      step(1'b1, DW'(11), 1'b0);
      check("bp_data", out_data, win4(0));
      check("bp_no_accept", OW'(acc), OW'(0));
    end
    for (int p = 11; p <= 15; p++) step(1'b1, DW'(p), 1'b1);
    drain();
    compare_basic(0);

    // Source gaps.
    clear_log();
    send_frame(0, 16, 50, 100, 1'b0);
    drain();
    compare_basic(0);

    // Back-to-back frames.
    clear_log();
    send_frame(0, 16, 100, 100, 1'b0);
    send_frame(100, 16, 100, 100, 1'b0);
    drain();
    check("b2b_count", OW'(got_d.size()), OW'(8));
    if (got_d.size() == 8) check("b2b_first2", got_d[4], win4(100));
    nlast = 0;
    foreach (got_l[i]) if (got_l[i]) nlast++;
    check("b2b_lasts", OW'(nlast), OW'(2));

    // Reset mid-frame while a window is being held.
    clear_log();
    for (int p = 0; p <= 10; p++) step(1'b1, DW'(p), 1'b1);
    step(1'b0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", OW'(out_valid), OW'(0));
    check("arst_last", OW'(out_last), OW'(0));
    check("arst_data", out_data, OW'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    send_frame(0, 16, 100, 100, 1'b0);
    drain();
    compare_basic(0);

    // Randomized data and handshakes over several frames.
    clear_log();
    for (int f = 0; f < 4; f++) send_frame(0, 16, 70, 60, 1'b1);
    drain();
    check("rnd_count", OW'(got_d.size()), OW'(16));
    nlast = 0;
    foreach (got_l[i]) if (got_l[i]) nlast++;
    check("rnd_lasts", OW'(nlast), OW'(4));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
